// File: rtl/alu_seq.sv
// alu_seq: sequencer and CCR owner for an external combinational 16-bit Alu.
// Word ops take one Alu pass. Long ops take two passes, low word then high word,
// with the carry chained between them.
module alu_seq #(
    parameter int unsigned BITS = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              size,
    input  logic [2:0]        op,
    input  logic              use_x,
    input  logic [2*BITS-1:0] dst,
    input  logic [2*BITS-1:0] src,
    input  logic              ccr_wr,
    input  logic [4:0]        ccr_din,
    output logic [BITS-1:0]   alu_a,
    output logic [BITS-1:0]   alu_b,
    output logic [2:0]        alu_op,
    output logic              alu_x,
    input  logic [BITS-1:0]   alu_o,
    input  logic              alu_c,
    input  logic              alu_z,
    input  logic              alu_v,
    input  logic              alu_n,
    output logic [2*BITS-1:0] result,
    output logic [4:0]        ccr,
    output logic              busy,
    output logic              done
);

    localparam int unsigned LW = 2 * BITS;

    // CCR bit positions
    localparam int unsigned CX = 4;
    localparam int unsigned CZ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [2:0]        op_q, op_n;
    logic              size_q, size_n;
    logic              use_x_q, use_x_n;
    logic [LW-1:0]     dst_q, dst_n;
    logic [LW-1:0]     src_q, src_n;
    logic [BITS-1:0]   lo_q, lo_n;
    logic              carry_q, carry_n;
    logic              zlo_q, zlo_n;
    logic [LW-1:0]     result_n;
    logic [4:0]        ccr_n;
    logic              done_n;
    logic              busy_n;
    logic [BITS-1:0]   alu_a_n;
    logic [BITS-1:0]   alu_b_n;
    logic [2:0]        alu_op_n;
    logic              alu_x_n;

    // Flags produced by the final pass of the current op
    logic              zeff;
    logic              z_new;
    logic              x_new;
    logic [4:0]        ccr_upd;

    // Final-pass CCR value: long Z spans both words, extended ops keep Z sticky
    always_comb begin
        zeff    = size_q ? (zlo_q & alu_z) : alu_z;
        z_new   = use_x_q ? (ccr[CZ] & zeff) : zeff;
        x_new   = (op_q == 3'd0 || op_q == 3'd1) ? alu_c : ccr[CX];
        ccr_upd = {x_new, alu_n, z_new, alu_v, alu_c};
    end

    // Next-state and next-register values; Alu drive is registered one step ahead
    always_comb begin
        state_n  = state;
        op_n     = op_q;
        size_n   = size_q;
        use_x_n  = use_x_q;
        dst_n    = dst_q;
        src_n    = src_q;
        lo_n     = lo_q;
        carry_n  = carry_q;
        zlo_n    = zlo_q;
        result_n = result;
        ccr_n    = ccr;
        done_n   = 1'b0;
        busy_n   = 1'b0;
        alu_a_n  = '0;
        alu_b_n  = '0;
        alu_op_n = 3'd0;
        alu_x_n  = 1'b0;

        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (ccr_wr) begin
                    ccr_n = ccr_din;
                end
                if (start) begin
                    state_n  = LO;
                    op_n     = op;
                    size_n   = size;
                    use_x_n  = use_x;
                    dst_n    = dst;
                    src_n    = src;
                    busy_n   = 1'b1;
                    alu_a_n  = dst[BITS-1:0];
                    alu_b_n  = src[BITS-1:0];
                    alu_op_n = op;
                    alu_x_n  = use_x & ccr_n[CX];
                end
            end

            LO: begin
                if (size_q) begin
                    state_n  = HI;
                    lo_n     = alu_o;
                    carry_n  = alu_c;
                    zlo_n    = alu_z;
                    busy_n   = 1'b1;
                    alu_a_n  = dst_q[LW-1:BITS];
                    alu_b_n  = src_q[LW-1:BITS];
                    alu_op_n = op_q;
                    alu_x_n  = alu_c;
                end else begin
                    state_n  = DONE;
                    result_n = {dst_q[LW-1:BITS], alu_o};
                    ccr_n    = ccr_upd;
                    done_n   = 1'b1;
                end
            end

            HI: begin
                state_n  = DONE;
                result_n = {alu_o, lo_q};
                ccr_n    = ccr_upd;
                done_n   = 1'b1;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            op_q    <= 3'd0;
            size_q  <= 1'b0;
            use_x_q <= 1'b0;
            dst_q   <= '0;
            src_q   <= '0;
            lo_q    <= '0;
            carry_q <= 1'b0;
            zlo_q   <= 1'b0;
            result  <= '0;
            ccr     <= 5'd0;
            done    <= 1'b0;
            busy    <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= 3'd0;
            alu_x   <= 1'b0;
        end else begin
            state   <= state_n;
            op_q    <= op_n;
            size_q  <= size_n;
            use_x_q <= use_x_n;
            dst_q   <= dst_n;
            src_q   <= src_n;
            lo_q    <= lo_n;
            carry_q <= carry_n;
            zlo_q   <= zlo_n;
            result  <= result_n;
            ccr     <= ccr_n;
            done    <= done_n;
            busy    <= busy_n;
            alu_a   <= alu_a_n;
            alu_b   <= alu_b_n;
            alu_op  <= alu_op_n;
            alu_x   <= alu_x_n;
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Sequencer and condition-code owner for the 16-bit Alu.
- Runs word operations in one ALU pass and long operations in two passes: the low word first, then the high word with the carry chained between them.
- Maintains the 68k-style CCR (X N Z V C), including sticky-Z semantics for extended (ADDX/SUBX-style) ops.
- Sits between the execution-unit decoder and a combinational Alu instance. The Alu is external; this block drives its inputs and samples its outputs.

Parameters:
- BITS, 16, Alu width. Long operand width is 2*BITS.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- start  in  1  request a new operation; sampled only when busy=0
- size  in  1  0=word, 1=long
- op  in  3  Alu opcode, passed through; 0=add, 1=sub (dst-src); others are non-arithmetic
- use_x  in  1  extended op: carry-in = X, Z sticky
- dst  in  2*BITS  first operand; drives alu_a
- src  in  2*BITS  second operand; drives alu_b
- ccr_wr  in  1  direct CCR load (MOVE to CCR)
- ccr_din  in  5  CCR load value
- alu_a  out  BITS  Alu operand a
- alu_b  out  BITS  Alu operand b
- alu_op  out  3  Alu opcode
- alu_x  out  1  Alu carry/borrow-in
- alu_o  in  BITS  Alu result
- alu_c, alu_z, alu_v, alu_n  in  1 each  Alu flags
- result  out  2*BITS  registered result
- ccr  out  5  [4]=X [3]=N [2]=Z [1]=V [0]=C
- busy  out  1  high in LO and HI states
- done  out  1  one-cycle pulse, result/ccr valid

Behaviour:
- Reset (async, any state): state=IDLE; result=0, ccr=0, done=0, busy=0; latched operands and carry cleared; an in-flight op is abandoned with no flag update.
- States: IDLE, LO, HI, DONE.
- Start acceptance: start with busy=0 (IDLE or DONE) latches op, size, use_x, dst, src and goes to LO.
  - Start while busy=1 is ignored; operands are not re-latched.
- ALU outputs: alu_a/alu_b/alu_op/alu_x are driven from latched values only. In IDLE/DONE all are 0 (op=0).
- LO state:
  - alu_a=dst[BITS-1:0], alu_b=src[BITS-1:0], alu_x = use_x ? ccr.X : 0.
  - Word: register result={dst[2BITS-1:BITS], alu_o} (upper half preserved), update CCR, go to DONE.
  - Long: latch low result, carry=alu_c, zlo=alu_z; go to HI.
- HI state:
  - alu_a/alu_b = upper halves, alu_x=carry.
  - Register result={alu_o, low}, update CCR, go to DONE.
- DONE: done=1 for one cycle, then IDLE, unless start is accepted, in which case go to LO.
- Latency: start to done is 2 cycles for word and 3 cycles for long.
- CCR update at the end of the final pass:
  - N=alu_n, V=alu_v, C=alu_c.
  - Zeff = alu_z for word; zlo & alu_z for long.
  - Z = use_x ? (ccr.Z & Zeff) : Zeff.
  - X = C when op is 0 or 1; otherwise X is unchanged.
- ccr_wr: ccr<=ccr_din when busy=0. Ignored while busy=1. Since flag writes only occur while busy, there is no same-cycle conflict.
- result and ccr hold their values between operations.

Test Plan:
- Word add, dst=0000_7FFF, src=0000_0001, ccr=0 -> done at cycle 2; result=0000_8000; ccr=01010 (N=1, V=1).
- Long add, dst=0000_FFFF, src=0000_0001 -> done at cycle 3; result=0001_0000; ccr=00000, confirming the low-word carry feeds the high pass.
- Long add, dst=FFFF_FFFF, src=0000_0001 -> result=0000_0000; ccr=10101 (X, Z, C).
- Extended long add: ccr_wr with 10100 (X=1, Z=1), use_x=1, dst=0, src=FFFF_FFFF -> result=0000_0000; Z stays 1; ccr=10101. Repeat with dst=0000_0001 -> result=0000_0001; Z=0.
- Word add, dst=ABCD_0001, src=0000_0001 -> result=ABCD_0002, upper half preserved.
- Start pulsed during HI is ignored. RST asserted in HI -> done never pulses; result=0, ccr=0. Next start after reset completes normally.
